// File: rtl/if_id_skid_if.sv
// IF/ID handshake bundle: fetch-side request/ready and decode-side
// valid/ready with the instruction payload.
interface if_id_skid_if #(
    parameter int INST_W = 32,
    parameter int ADDR_W = 32
);
    logic              valid_i;
    logic              ready_o;
    logic [INST_W-1:0] inst_i;
    logic [ADDR_W-1:0] inst_addr_i;
    logic              pred_i;
    logic              valid_o;
    logic              ready_i;
    logic [INST_W-1:0] inst_o;
    logic [ADDR_W-1:0] inst_addr_o;
    logic              pred_o;

    modport slave (
        input  valid_i, inst_i, inst_addr_i, pred_i, ready_i,
        output ready_o, valid_o, inst_o, inst_addr_o, pred_o
    );

    modport master (
        output valid_i, inst_i, inst_addr_i, pred_i, ready_i,
        input  ready_o, valid_o, inst_o, inst_addr_o, pred_o
    );
endinterface

// File: rtl/if_id_skid.sv
// IF/ID pipeline register with a two-entry skid buffer; ready_o is a
// flop so decode stalls never reach fetch combinationally.
module if_id_skid #(
    parameter int                INST_W     = 32,
    parameter int                ADDR_W     = 32,
    parameter logic [INST_W-1:0] NOP_INST   = 32'h00000013,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    if_id_skid_if.slave   bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              ready_q, ready_d;
    logic [INST_W-1:0] m_inst_q, m_inst_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic              m_pred_q, m_pred_d;
    logic [INST_W-1:0] s_inst_q, s_inst_d;
    logic [ADDR_W-1:0] s_addr_q, s_addr_d;
    logic              s_pred_q, s_pred_d;
    logic              accept, deliver, m_valid;

    assign m_valid = (state_q != EMPTY);
    assign accept  = bus.valid_i & ready_q;
    assign deliver = m_valid & bus.ready_i;

    always_comb begin
        state_d  = state_q;
        m_inst_d = m_inst_q;
        m_addr_d = m_addr_q;
        m_pred_d = m_pred_q;
        s_inst_d = s_inst_q;
        s_addr_d = s_addr_q;
        s_pred_d = s_pred_q;
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        m_inst_d = bus.inst_i;
                        m_addr_d = bus.inst_addr_i;
                        m_pred_d = bus.pred_i;
                        state_d  = BUSY;
                    end
                end
                BUSY: begin
                    if (accept && deliver) begin
                        m_inst_d = bus.inst_i;
                        m_addr_d = bus.inst_addr_i;
                        m_pred_d = bus.pred_i;
                    end else if (accept) begin
                        s_inst_d = bus.inst_i;
                        s_addr_d = bus.inst_addr_i;
                        s_pred_d = bus.pred_i;
                        state_d  = FULL;
                    end else if (deliver) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (deliver) begin
                        m_inst_d = s_inst_q;
                        m_addr_d = s_addr_q;
                        m_pred_d = s_pred_q;
                        state_d  = BUSY;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        ready_d = (state_d != FULL);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= EMPTY;
            ready_q  <= 1'b1;
            m_inst_q <= NOP_INST;
            m_addr_q <= RESET_ADDR;
            m_pred_q <= 1'b0;
            s_inst_q <= '0;
            s_addr_q <= '0;
            s_pred_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            m_inst_q <= m_inst_d;
            m_addr_q <= m_addr_d;
            m_pred_q <= m_pred_d;
            s_inst_q <= s_inst_d;
            s_addr_q <= s_addr_d;
            s_pred_q <= s_pred_d;
        end
    end

    // Address is left visible when empty; data and flag are masked.
    assign bus.ready_o     = ready_q;
    assign bus.valid_o     = m_valid;
    assign bus.inst_o      = m_valid ? m_inst_q : NOP_INST;
    assign bus.inst_addr_o = m_addr_q;
    assign bus.pred_o      = m_valid & m_pred_q;

endmodule

// File: tb/tb_if_id_skid.sv
// Directed vector table plus reset/random sequences for if_id_skid.
module tb_if_id_skid;

    localparam logic [31:0] NOP = 32'h00000013;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush_i = 1'b0;
    int unsigned n_tests = 0;
    int unsigned n_fail = 0;

    if_id_skid_if #(.INST_W(32), .ADDR_W(32)) bus ();

    if_id_skid dut (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush_i),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] inst;
        logic [31:0] addr;
        logic        pred;
        logic        fl;
        logic        rdy;
        logic        ev;
        logic        er;
        logic [31:0] einst;
        logic [31:0] eaddr;
        logic        epred;
    } vec_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
        logic        pred;
    } ent_t;

    vec_t vecs[$];
    ent_t sb[$];

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(logic v, logic [31:0] inst, logic [31:0] addr,
                       logic pred, logic fl, logic rdy, logic ev,
                       logic er, logic [31:0] einst,
                       logic [31:0] eaddr, logic epred);
        vec_t t;
        t.v = v; t.inst = inst; t.addr = addr; t.pred = pred;
        t.fl = fl; t.rdy = rdy; t.ev = ev; t.er = er;
        t.einst = einst; t.eaddr = eaddr; t.epred = epred;
        vecs.push_back(t);
    endtask

    task automatic drive(logic v, logic [31:0] inst, logic [31:0] addr,
                         logic pred, logic fl, logic rdy);
        bus.valid_i     = v;
        bus.inst_i      = inst;
        bus.inst_addr_i = addr;
        bus.pred_i      = pred;
        flush_i         = fl;
        bus.ready_i     = rdy;
    endtask

    task automatic chk_out(string tag, logic ev, logic er,
                           logic [31:0] ei, logic [31:0] ea, logic ep);
        chk({tag, ".valid"}, 128'(bus.valid_o), 128'(ev));
        chk({tag, ".ready"}, 128'(bus.ready_o), 128'(er));
        chk({tag, ".inst"}, 128'(bus.inst_o), 128'(ei));
        chk({tag, ".addr"}, 128'(bus.inst_addr_o), 128'(ea));
        chk({tag, ".pred"}, 128'(bus.pred_o), 128'(ep));
    endtask

    initial begin
        ent_t cur, prev;
        logic stall_prev;
        logic acc, del, v, r, f;

        // first vector, then 8-entry stream, then idle with junk
        add(1, 32'h00500093, 32'h0, 0, 0, 1, 1, 1, 32'h00500093, 32'h0, 0);
        for (int i = 0; i < 8; i++) begin
            add(1, 32'hA0000000 + i, 32'(4 * i), i[0], 0, 1,
                1, 1, 32'hA0000000 + i, 32'(4 * i), i[0]);
        end
        add(0, 32'hDEADBEEF, 32'hFFC, 1, 0, 1, 0, 1, NOP, 32'h1C, 0);
        // stall: A, B into skid, hold, drain
        add(1, 32'hAAAA0001, 32'h10, 1, 0, 0, 1, 1, 32'hAAAA0001, 32'h10, 1);
        add(1, 32'hBBBB0002, 32'h14, 1, 0, 0, 1, 0, 32'hAAAA0001, 32'h10, 1);
        add(0, 32'h12345678, 32'h99, 0, 0, 0, 1, 0, 32'hAAAA0001, 32'h10, 1);
        add(0, 32'h12345678, 32'h99, 0, 0, 1, 1, 1, 32'hBBBB0002, 32'h14, 1);
        add(0, 32'h12345678, 32'h99, 0, 0, 1, 0, 1, NOP, 32'h14, 0);
        // flush while FULL with C offered
        add(1, 32'hAAAA0001, 32'h10, 1, 0, 0, 1, 1, 32'hAAAA0001, 32'h10, 1);
        add(1, 32'hBBBB0002, 32'h14, 1, 0, 0, 1, 0, 32'hAAAA0001, 32'h10, 1);
        add(1, 32'hCCCC0003, 32'h18, 1, 1, 0, 0, 1, NOP, 32'h10, 0);
        add(0, 32'h0, 32'h0, 0, 0, 1, 0, 1, NOP, 32'h10, 0);
        // flush in BUSY with simultaneous accept and deliver
        add(1, 32'hDDDD0004, 32'h20, 0, 0, 0, 1, 1, 32'hDDDD0004, 32'h20, 0);
        add(1, 32'hEEEE0005, 32'h24, 1, 1, 1, 0, 1, NOP, 32'h20, 0);
        add(1, 32'hFFFF0006, 32'h28, 0, 0, 1, 1, 1, 32'hFFFF0006, 32'h28, 0);

        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 0, 1, NOP, 32'h0, 0);
        rst = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].v, vecs[i].inst, vecs[i].addr, vecs[i].pred,
                  vecs[i].fl, vecs[i].rdy);
            @(posedge clk);
            #1;
            chk_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].er,
                    vecs[i].einst, vecs[i].eaddr, vecs[i].epred);
        end

        // async reset pulse while BUSY holding F
        drive(0, 0, 0, 0, 0, 0);
        #2 rst = 1'b0;
        #1;
        chk_out("areset", 0, 1, NOP, 32'h0, 0);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        chk_out("areset_hold", 0, 1, NOP, 32'h0, 0);

        // randomised traffic against a FIFO scoreboard
        stall_prev = 1'b0;
        prev = '0;
        for (int c = 0; c < 400; c++) begin
            cur = '{bus.inst_o, bus.inst_addr_o, bus.pred_o};
            chk("rnd.valid", 128'(bus.valid_o), 128'(sb.size() > 0));
            chk("rnd.ready", 128'(bus.ready_o), 128'(sb.size() < 2));
            if (sb.size() > 0) chk("rnd.order", 128'(cur), 128'(sb[0]));
            else chk("rnd.nop", 128'({bus.inst_o, bus.pred_o}),
                     128'({NOP, 1'b0}));
            if (stall_prev) chk("rnd.stable", 128'(cur), 128'(prev));
            v = ($urandom_range(0, 9) < 7);
            r = ($urandom_range(0, 9) < 6);
            f = ($urandom_range(0, 19) == 0);
            drive(v, $urandom, $urandom, 1'($urandom), f, r);
            acc = v & bus.ready_o;
            del = bus.valid_o & r;
            stall_prev = bus.valid_o & ~r & ~f;
            prev = cur;
            @(posedge clk);
            #1;
            if (del && sb.size() > 0) void'(sb.pop_front());
            if (f) sb.delete();
            else if (acc) sb.push_back('{bus.inst_i, bus.inst_addr_i,
                                        bus.pred_i});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
